// File: rtl/uart_reg_bank.sv
// UART-side register bank: control/status, RR shadow reads,
// ECG sample staging into a ready/valid stream, W1C event flags.
module uart_reg_bank #(
  parameter int          N_CH     = 2,
  parameter int          SAMPLE_W = 11,
  parameter int          RR_W     = 11,
  parameter logic [7:0]  VERSION  = 8'h21,
  localparam int         CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [2:0]          i_rwaddr,
  input  logic [7:0]          i_write_data,
  input  logic                i_wr_req,
  input  logic                i_rd_req,
  input  logic [RR_W-1:0]     i_rr_period,
  input  logic                i_rr_vld,
  input  logic [7:0]          i_status,
  input  logic                i_ecg_rdy,
  output logic [7:0]          o_read_data,
  output logic                o_read_vld,
  output logic [SAMPLE_W-1:0] o_ecg_value,
  output logic [CH_W-1:0]     o_ecg_ch,
  output logic                o_ecg_value_vld,
  output logic                o_alg_en,
  output logic                o_src_sel,
  output logic                o_alg_rst,
  output logic                o_irq
);

  localparam logic [2:0] A_CR    = 3'd0;
  localparam logic [2:0] A_SR    = 3'd1;
  localparam logic [2:0] A_ER    = 3'd2;
  localparam logic [2:0] A_DOUTL = 3'd3;
  localparam logic [2:0] A_DOUTH = 3'd4;
  localparam logic [2:0] A_DINL  = 3'd5;
  localparam logic [2:0] A_DINH  = 3'd6;
  localparam logic [2:0] A_ID    = 3'd7;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  localparam logic [2:0] CH_MAX = 3'(N_CH - 1);
  localparam int         HI_W   = SAMPLE_W - 8;
  localparam int         SH_W   = RR_W - 8;

  logic [6:0]          cr_q, cr_d;
  logic                alg_rst_q, alg_rst_d;
  logic [2:0]          er_q, er_d;
  logic [2:0]          er_set, er_clr;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [7:0]          lo_q, lo_d;
  logic [HI_W-1:0]     hi_q, hi_d;
  logic [0:0]          st_q, st_d;
  logic [SAMPLE_W-1:0] val_q, val_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                rvld_q;
  logic                ovr_set;
  logic [2:0]          ch_req;

  logic wr_cr, wr_er, wr_dinl, commit, rd_lo;

  assign wr_cr   = i_wr_req && (i_rwaddr == A_CR);
  assign wr_er   = i_wr_req && (i_rwaddr == A_ER);
  assign wr_dinl = i_wr_req && (i_rwaddr == A_DINL);
  assign commit  = i_wr_req && (i_rwaddr == A_DINH);
  assign rd_lo   = i_rd_req && (i_rwaddr == A_DOUTL);

  // Control register with channel clamp; alg_rst is a pulse, never stored
  always_comb begin
    ch_req    = i_write_data[6:4];
    cr_d      = cr_q;
    alg_rst_d = wr_cr && i_write_data[2];
    if (wr_cr) begin
      cr_d = {(ch_req > CH_MAX) ? CH_MAX : ch_req,
              i_write_data[3], 1'b0,
              i_write_data[1:0]};
    end
  end

  // RR capture and high-byte shadow taken on every low-byte read
  always_comb begin
    rr_d = i_rr_vld ? i_rr_period : rr_q;
    sh_d = rd_lo ? rr_q[RR_W-1:8] : sh_q;
  end

  // Staging bytes and the sample hand-off FSM
  always_comb begin
    lo_d    = wr_dinl ? i_write_data : lo_q;
    hi_d    = commit ? i_write_data[HI_W-1:0] : hi_q;
    st_d    = st_q;
    val_d   = val_q;
    ch_d    = ch_q;
    ovr_set = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (commit) begin
          st_d  = S_PEND;
          val_d = {i_write_data[HI_W-1:0], lo_q};
          ch_d  = cr_q[4 +: CH_W];
        end
      end
      S_PEND: begin
        if (i_ecg_rdy) begin
          if (commit) begin
            val_d = {i_write_data[HI_W-1:0], lo_q};
            ch_d  = cr_q[4 +: CH_W];
          end else begin
            st_d = S_IDLE;
          end
        end else if (commit) begin
          ovr_set = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Sticky event flags: hardware set beats a same-cycle clear
  always_comb begin
    er_set = {i_rr_vld, i_rr_vld && er_q[2], ovr_set};
    er_clr = (wr_er ? i_write_data[2:0] : 3'b000)
           | {rd_lo, 2'b00};
    er_d   = (er_q & ~er_clr) | er_set;
  end

  // Read mux, sampled from pre-write state
  always_comb begin
    rdata_d = 8'h00;
    if (i_rd_req) begin
      case (i_rwaddr)
        A_CR:    rdata_d = {1'b0, cr_q};
        A_SR:    rdata_d = i_status;
        A_ER:    rdata_d = {5'b0, er_q};
        A_DOUTL: rdata_d = rr_q[7:0];
        A_DOUTH: rdata_d = 8'(sh_q);
        A_DINL:  rdata_d = lo_q;
        A_DINH:  rdata_d = 8'(hi_q);
        A_ID:    rdata_d = VERSION;
        default: rdata_d = 8'h00;
      endcase
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cr_q      <= '0;
      alg_rst_q <= 1'b0;
      er_q      <= '0;
      rr_q      <= '0;
      sh_q      <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      st_q      <= S_IDLE;
      val_q     <= '0;
      ch_q      <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
    end else begin
      cr_q      <= cr_d;
      alg_rst_q <= alg_rst_d;
      er_q      <= er_d;
      rr_q      <= rr_d;
      sh_q      <= sh_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      st_q      <= st_d;
      val_q     <= val_d;
      ch_q      <= ch_d;
      rdata_q   <= rdata_d;
      rvld_q    <= i_rd_req;
    end
  end

  assign o_read_data     = rdata_q;
  assign o_read_vld      = rvld_q;
  assign o_ecg_value     = val_q;
  assign o_ecg_ch        = ch_q;
  assign o_ecg_value_vld = (st_q == S_PEND);
  assign o_alg_en        = cr_q[0];
  assign o_src_sel       = cr_q[1];
  assign o_alg_rst       = alg_rst_q;
  assign o_irq           = cr_q[3] && (|er_q);

endmodule
